// File: rtl/nco_sweep_ctrl.sv
// Stepped linear-chirp generator feeding the NCO phase-increment port.
// Optional step counter output enabled by defining NCO_SWEEP_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start; phi_inc_o holds its last value
// HOLD  | dwelling on the current tuning word
// FIN   | end-of-sweep decision; resolved on the edge ending the last point
module nco_sweep_ctrl #(
  parameter int apr = 32,
  parameter int dwc = 16
`ifdef NCO_SWEEP_CNT_EN
  ,
  parameter int scw = 16
`endif
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic           mode_rpt,
  input  logic [apr-1:0] f_start,
  input  logic [apr-1:0] f_stop,
  input  logic [apr-1:0] f_step,
  input  logic [dwc-1:0] dwell,
  output logic [apr-1:0] phi_inc_o,
  output logic           busy,
  output logic           done,
  output logic           wrap
`ifdef NCO_SWEEP_CNT_EN
  ,
  output logic [scw-1:0] step_idx
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, FIN} state_t;

  state_t         state;
  logic [apr-1:0] start_q, stop_q, step_q;
  logic [dwc-1:0] dwell_q, cnt;
  logic           rpt_q, dir_dn, single_q;

  logic [apr:0]   sum, diff;
  logic [apr-1:0] next_phi;
  logic           last_pt;

  // One extra bit exposes carry/borrow so a wrapped result clamps to f_stop.
  always_comb begin
    sum      = {1'b0, phi_inc_o} + {1'b0, step_q};
    diff     = {1'b0, phi_inc_o} - {1'b0, step_q};
    next_phi = sum[apr-1:0];
    if (dir_dn) begin
      if (diff[apr] || (diff[apr-1:0] < stop_q)) next_phi = stop_q;
      else                                       next_phi = diff[apr-1:0];
    end else begin
      if (sum[apr] || (sum[apr-1:0] > stop_q))   next_phi = stop_q;
      else                                       next_phi = sum[apr-1:0];
    end
    last_pt = single_q || (phi_inc_o == stop_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phi_inc_o <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
      rpt_q     <= 1'b0;
      dir_dn    <= 1'b0;
      single_q  <= 1'b0;
`ifdef NCO_SWEEP_CNT_EN
      step_idx  <= '0;
`endif
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            start_q   <= f_start;
            stop_q    <= f_stop;
            step_q    <= f_step;
            dwell_q   <= dwell;
            rpt_q     <= mode_rpt;
            dir_dn    <= (f_stop < f_start);
            single_q  <= (f_step == '0) || (f_start == f_stop);
            phi_inc_o <= f_start;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= HOLD;
`ifdef NCO_SWEEP_CNT_EN
            step_idx  <= '0;
`endif
          end
        end
        HOLD: begin
          if (abort) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (clken) begin
            if (cnt != dwell_q) begin
              cnt <= cnt + dwc'(1);
            end else begin
              cnt <= '0;
              if (last_pt) begin
                // FIN work done in place so the sweep end costs no extra clk
                if (rpt_q) begin
                  wrap      <= 1'b1;
                  phi_inc_o <= start_q;
`ifdef NCO_SWEEP_CNT_EN
                  step_idx  <= '0;
`endif
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else begin
                phi_inc_o <= next_phi;
`ifdef NCO_SWEEP_CNT_EN
                if (step_idx != '1) step_idx <= step_idx + scw'(1);
`endif
              end
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: table of directed sweeps, hand-written corner
// sequences, then randomized traffic against a point-list reference model.
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clken = 1'b0, start = 1'b0, abort = 1'b0, mode_rpt = 1'b0;
  logic [31:0] f_start = '0, f_stop = '0, f_step = '0;
  logic [15:0] dwell = '0;
  logic [31:0] phi_inc_o;
  logic        busy, done, wrap;
`ifdef NCO_SWEEP_CNT_EN
  logic [15:0] step_idx;
`endif

  nco_sweep_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .start     (start),
    .abort     (abort),
    .mode_rpt  (mode_rpt),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phi_inc_o (phi_inc_o),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
`ifdef NCO_SWEEP_CNT_EN
    ,
    .step_idx  (step_idx)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {29'd0, busy, done, wrap, phi_inc_o};
  endfunction

  function automatic logic [63:0] expo(input logic b, input logic d, input logic w, input logic [31:0] p);
    return {29'd0, b, d, w, p};
  endfunction

  typedef struct {
    logic [31:0]       fs, fe, st;
    logic [15:0]       dw;
    int                npts;
    logic [0:5][31:0]  pts;
  } sweep_vec_t;

  sweep_vec_t tbl[7];

  // reference model: the sweep as a precomputed list of points
  logic [31:0] pts[$];
  logic        m_busy = 0, m_done = 0, m_wrap = 0, m_rpt = 0;
  logic [31:0] m_phi = '0;
  logic [15:0] m_idx = '0, m_dw = '0;
  int          m_pi = 0, m_cnt = 0;

  task automatic build_points();
    longint p, e, s, n;
    p = longint'(f_start);
    e = longint'(f_stop);
    s = longint'(f_step);
    pts.delete();
    pts.push_back(f_start);
    if (s != 0 && p != e) begin
      for (int g = 0; g < 100000; g++) begin
        n = (e > p) ? p + s : p - s;
        if ((e > p && n >= e) || (e < p && n <= e)) begin
          pts.push_back(f_stop);
          break;
        end
        pts.push_back(32'(n));
        p = n;
      end
    end
  endtask

  task automatic model_update();
    m_done = 0;
    m_wrap = 0;
    if (!m_busy) begin
      if (start && !abort) begin
        build_points();
        m_pi = 0; m_cnt = 0; m_phi = pts[0]; m_busy = 1; m_idx = '0;
        m_dw = dwell; m_rpt = mode_rpt;
      end
    end else if (abort) begin
      m_busy = 0;
    end else if (clken) begin
      m_cnt++;
      if (m_cnt == int'(m_dw) + 1) begin
        m_cnt = 0;
        if (m_pi == pts.size() - 1) begin
          if (m_rpt) begin
            m_pi = 0; m_phi = pts[0]; m_wrap = 1; m_idx = '0;
          end else begin
            m_done = 1; m_busy = 0;
          end
        end else begin
          m_pi++;
          m_phi = pts[m_pi];
          if (m_idx != 16'hFFFF) m_idx++;
        end
      end
    end
  endtask

  task automatic run_table(input int i);
    logic [31:0] last;
    mode_rpt = 0; abort = 0; clken = 1;
    f_start = tbl[i].fs; f_stop = tbl[i].fe; f_step = tbl[i].st; dwell = tbl[i].dw;
    start = 1;
    tick();
    start = 0;
    f_start = ~f_start; f_stop = ~f_stop; f_step = 32'd3; dwell = 16'd9;
    for (int k = 0; k < tbl[i].npts; k++) begin
      for (int c = 0; c <= int'(tbl[i].dw); c++) begin
        if (k != 0 || c != 0) tick();
        chk($sformatf("tbl%0d_pt%0d", i, k), outs(), expo(1, 0, 0, tbl[i].pts[k]));
      end
    end
    last = tbl[i].pts[tbl[i].npts-1];
    tick();
    chk($sformatf("tbl%0d_done", i), outs(), expo(0, 1, 0, last));
    tick();
    chk($sformatf("tbl%0d_idle", i), outs(), expo(0, 0, 0, last));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    logic [31:0] rp_phi[7];
    logic        rp_wrap[7];

    tbl[0] = '{32'd100, 32'd130, 32'd10, 16'd2, 4, {32'd100, 32'd110, 32'd120, 32'd130, 32'd0, 32'd0}};
    tbl[1] = '{32'd0,   32'd25,  32'd10, 16'd0, 4, {32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd0}};
    tbl[2] = '{32'h15,  32'h03,  32'h10, 16'd0, 3, {32'h15, 32'h05, 32'h03, 32'd0, 32'd0, 32'd0}};
    tbl[3] = '{32'd50,  32'd50,  32'd7,  16'd1, 1, {32'd50, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[4] = '{32'd40,  32'd90,  32'd0,  16'd1, 1, {32'd40, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[5] = '{32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h10, 16'd0, 2,
               {32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0}};
    tbl[6] = '{32'd200, 32'd100, 32'd60, 16'd1, 3, {32'd200, 32'd140, 32'd100, 32'd0, 32'd0, 32'd0}};

    reset_n = 1;
    #2 reset_n = 0;
    #1;
    chk("reset_state", outs(), expo(0, 0, 0, 32'd0));
`ifdef NCO_SWEEP_CNT_EN
    chk("reset_idx", 64'(step_idx), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("idle_after_reset", outs(), expo(0, 0, 0, 32'd0));

    for (int i = 0; i < 7; i++) run_table(i);

    // clken alternating, dwell=1 -> 4 clk per point; abort in second point
    f_start = 0; f_stop = 100; f_step = 10; dwell = 1; mode_rpt = 0; clken = 1; start = 1;
    tick();
    start = 0;
    chk("gate_e0", outs(), expo(1, 0, 0, 32'd0));
    for (int e = 1; e <= 7; e++) begin
      clken = (e % 2 == 0);
      abort = (e == 6);
      tick();
      if (e <= 3)      chk($sformatf("gate_e%0d", e), outs(), expo(1, 0, 0, 32'd0));
      else if (e <= 5) chk($sformatf("gate_e%0d", e), outs(), expo(1, 0, 0, 32'd10));
      else             chk($sformatf("abort_e%0d", e), outs(), expo(0, 0, 0, 32'd10));
    end
    abort = 0; clken = 1;
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("abort_quiet", outs(), expo(0, 0, 0, 32'd10));
    end

    // repeat mode with start pulses and input changes during the sweep
    rp_phi  = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 32'd0};
    rp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    f_start = 0; f_stop = 20; f_step = 10; dwell = 0; mode_rpt = 1; clken = 1; start = 1;
    for (int e = 0; e < 7; e++) begin
      if (e > 0) begin
        start = (e % 2 == 0);
        f_start = 32'd77; f_stop = 32'd5; mode_rpt = 0;
      end
      tick();
      chk($sformatf("rpt_e%0d", e), outs(), expo(1, 0, rp_wrap[e], rp_phi[e]));
`ifdef NCO_SWEEP_CNT_EN
      chk($sformatf("rpt_idx_e%0d", e), 64'(step_idx), 64'(e % 3));
`endif
    end
    start = 0; abort = 1;
    tick();
    chk("rpt_abort", outs(), expo(0, 0, 0, 32'd0));
    abort = 0;

    // abort and start together in IDLE: no sweep
    f_start = 32'd55; f_stop = 32'd80; f_step = 1; start = 1; abort = 1;
    tick();
    chk("abort_start_idle", outs(), expo(0, 0, 0, 32'd0));
    start = 0; abort = 0;
    tick();
    chk("abort_start_idle2", outs(), expo(0, 0, 0, 32'd0));

    // abort on the edge that would finish the sweep suppresses done
    f_start = 0; f_stop = 10; f_step = 10; dwell = 0; mode_rpt = 0; start = 1;
    tick();
    start = 0;
    tick();
    chk("abort_fin_pre", outs(), expo(1, 0, 0, 32'd10));
    abort = 1;
    tick();
    chk("abort_fin", outs(), expo(0, 0, 0, 32'd10));
    abort = 0;
    tick();
    chk("abort_fin_after", outs(), expo(0, 0, 0, 32'd10));

    // asynchronous reset between edges in the middle of a sweep
    f_start = 100; f_stop = 200; f_step = 10; dwell = 3; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    chk("areset_pre", outs(), expo(1, 0, 0, 32'd110));
    #3 reset_n = 0;
    #1;
    chk("areset_now", outs(), expo(0, 0, 0, 32'd0));
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("areset_idle", outs(), expo(0, 0, 0, 32'd0));
    end

    // randomized traffic against the point-list model
    m_busy = 0; m_phi = '0; m_idx = '0; m_done = 0; m_wrap = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      clken    = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      mode_rpt = ($urandom_range(0, 2) == 0);
      base     = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FF00 : 32'd0;
      f_start  = base + 32'($urandom_range(0, 255));
      f_stop   = base + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)       f_step = '0;
      else if ($urandom_range(0, 15) == 0) f_step = 32'($urandom);
      else                                 f_step = 32'($urandom_range(1, 64));
      dwell    = 16'($urandom_range(0, 3));
      @(posedge clk);
      model_update();
      #1;
      chk("rand_outs", outs(), expo(m_busy, m_done, m_wrap, m_phi));
`ifdef NCO_SWEEP_CNT_EN
      chk("rand_idx", 64'(step_idx), 64'(m_idx));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
